// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, functs,
// FSM states and the ALU control encoding.
package mips_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_LWWB,
        S_MEMWR,
        S_REXE,
        S_RWB,
        S_ADDIEXE,
        S_ADDIWB,
        S_BEQEXE,
        S_JEXE
    } state_e;

    // ALU_ZERO gives a zero result for R-type functs outside the supported set.
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ZERO
    } alu_ctrl_e;

    function automatic alu_ctrl_e funct_to_alu(input logic [5:0] funct);
        alu_ctrl_e ctrl;
        case (funct)
            FN_ADD:  ctrl = ALU_ADD;
            FN_SUB:  ctrl = ALU_SUB;
            FN_AND:  ctrl = ALU_AND;
            FN_OR:   ctrl = ALU_OR;
            FN_SLT:  ctrl = ALU_SLT;
            default: ctrl = ALU_ZERO;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU shared by every datapath step of the core.
module mips_alu
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctrl_e        ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic lt;

    assign lt = ($signed(a) < $signed(b));

    // Operation select; arithmetic wraps, no overflow detection.
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_core.sv
// Multicycle MIPS-subset core: one shared memory port, one access per state.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  FETCH     | IR <- mem[PC], PC <- PC+4
//  DECODE    | A,B <- rs,rt; ALUOut <- branch target
//  MEMADR    | ALUOut <- A + signext(imm)
//  MEMRD     | MDR <- mem[ALUOut]
//  LWWB      | rt <- MDR
//  MEMWR     | mem[ALUOut] <- B
//  REXE      | ALUOut <- A op B
//  RWB       | rd <- ALUOut
//  ADDIEXE   | ALUOut <- A + signext(imm)
//  ADDIWB    | rt <- ALUOut
//  BEQEXE    | PC <- ALUOut when A == B
//  JEXE      | PC <- {PC[31:28], target, 00}
module mips_core
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;

    logic [WIDTH-1:0] rf_q [32];
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    logic [5:0]       op;
    logic [4:0]       rs, rt, rd;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] rs_val, rt_val;

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    alu_ctrl_e        alu_ctrl;
    logic             alu_zero;
    logic             memwr_state;

    assign op      = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign imm_ext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

    // $0 is hardwired to zero on the read side.
    assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

    mips_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Next-state, datapath steering and Moore outputs per state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        a_d         = a_q;
        b_d         = b_q;
        aluout_d    = aluout_q;
        alu_a       = pc_q;
        alu_b       = '0;
        alu_ctrl    = ALU_ADD;
        rf_we       = 1'b0;
        rf_waddr    = rt;
        rf_wdata    = aluout_q;
        memread     = 1'b0;
        memwr_state = 1'b0;
        adr         = aluout_q;

        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                adr     = pc_q;
                ir_d    = memdata;
                alu_a   = pc_q;
                alu_b   = WIDTH'(4);
                pc_d    = alu_res;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d      = rs_val;
                b_d      = rt_val;
                alu_a    = pc_q;
                alu_b    = {imm_ext[WIDTH-3:0], 2'b00};
                aluout_d = alu_res;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXE;
                    OP_ADDI:      state_d = S_ADDIEXE;
                    OP_BEQ:       state_d = S_BEQEXE;
                    OP_J:         state_d = S_JEXE;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_a    = a_q;
                alu_b    = imm_ext;
                aluout_d = alu_res;
                state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                mdr_d   = memdata;
                state_d = S_LWWB;
            end
            S_LWWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                rf_wdata = mdr_q;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memwr_state = 1'b1;
                state_d     = S_FETCH;
            end
            S_REXE: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = funct_to_alu(funct);
                aluout_d = alu_res;
                state_d  = S_RWB;
            end
            S_RWB: begin
                rf_we    = 1'b1;
                rf_waddr = rd;
                state_d  = S_FETCH;
            end
            S_ADDIEXE: begin
                alu_a    = a_q;
                alu_b    = imm_ext;
                aluout_d = alu_res;
                state_d  = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we    = 1'b1;
                rf_waddr = rt;
                state_d  = S_FETCH;
            end
            S_BEQEXE: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_ctrl = ALU_SUB;
                if (alu_zero) begin
                    pc_d = aluout_q;
                end
                state_d  = S_FETCH;
            end
            S_JEXE: begin
                pc_d    = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks the strobe immediately so an aborted store never reaches memory.
    assign memwrite  = memwr_state & reset;
    assign writedata = b_q;

    // State and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    // Register file is not cleared by reset; writes to $0 are dropped.
    always_ff @(posedge clk) begin
        if (reset && rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Directed-program bench for mips_core with a unified word memory model.
module tb_mips_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memdata;
    logic        memread;
    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;

    logic [31:0] mem [0:255];
    logic [31:0] img [0:255];
    logic        load_en = 1'b0;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;

    logic [31:0] wr_adr_q [$];
    logic [31:0] wr_dat_q [$];
    int          wr_cyc_q [$];
    logic [31:0] adr_at [0:127];

    mips_core #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memdata   (memdata),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata)
    );

    always #5 clk = ~clk;

    assign memdata = mem[adr[9:2]];

    // Memory model: image load while the core is held in reset, else store on strobe.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (memwrite) begin
            mem[adr[9:2]] <= writedata;
        end
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Per-cycle trace: cycle numbers count from 1 after reset release.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            wr_adr_q.delete();
            wr_dat_q.delete();
            wr_cyc_q.delete();
        end else begin
            if (cyc + 1 < 128) adr_at[cyc + 1] = adr;
            if (memwrite) begin
                wr_adr_q.push_back(adr);
                wr_dat_q.push_back(writedata);
                wr_cyc_q.push_back(cyc + 1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_a(input int i);
        return (i < wr_adr_q.size()) ? wr_adr_q[i] : 32'hdeadbeef;
    endfunction

    function automatic logic [31:0] wr_d(input int i);
        return (i < wr_dat_q.size()) ? wr_dat_q[i] : 32'hdeadbeef;
    endfunction

    function automatic logic [31:0] wr_c(input int i);
        return (i < wr_cyc_q.size()) ? 32'(wr_cyc_q[i]) : 32'hdeadbeef;
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'b000010, 26'(tgt)};
    endfunction

    function automatic logic [31:0] addi(input int rs, input int rt, input int imm);
        return enc_i(6'b001000, rs, rt, imm);
    endfunction

    function automatic logic [31:0] sw(input int rs, input int rt, input int imm);
        return enc_i(6'b101011, rs, rt, imm);
    endfunction

    function automatic logic [31:0] lw(input int rs, input int rt, input int imm);
        return enc_i(6'b100011, rs, rt, imm);
    endfunction

    function automatic logic [31:0] beq(input int rs, input int rt, input int imm);
        return enc_i(6'b000100, rs, rt, imm);
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    // Two reset edges (image loaded on the first), released just after an edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        load_en = 1'b1;
        @(posedge clk);
        #1 load_en = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_memwrite"}, {31'b0, memwrite}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Program 1: addi/addi/add/sw, checks reset outputs and store timing.
        clear_img();
        img[0] = addi(0, 2, 200);
        img[1] = addi(0, 3, 10);
        img[2] = enc_r(2, 3, 4, 6'b100000);
        img[3] = sw(0, 4, 255);
        img[4] = enc_j(4);
        do_reset("p1");
        @(negedge clk);
        chk("p1_first_adr", adr, 32'd0);
        chk("p1_first_memread", {31'b0, memread}, 32'd1);
        chk("p1_first_writedata", writedata, 32'd0);
        run(24);
        chk("p1_second_fetch_adr", adr_at[5], 32'd4);
        chk("p1_nwr", 32'(wr_adr_q.size()), 32'd1);
        chk("p1_sw_adr", wr_a(0), 32'd255);
        chk("p1_sw_data", wr_d(0), 32'd210);
        chk("p1_sw_cycle", wr_c(0), 32'd16);

        // Program 2: R-type results, unknown funct, write to $0.
        clear_img();
        img[0]  = addi(0, 2, 7);
        img[1]  = addi(0, 3, 5);
        img[2]  = enc_r(2, 3, 5, 6'b100010);
        img[3]  = sw(0, 5, 100);
        img[4]  = enc_r(2, 3, 5, 6'b100100);
        img[5]  = sw(0, 5, 100);
        img[6]  = enc_r(2, 3, 5, 6'b100101);
        img[7]  = sw(0, 5, 100);
        img[8]  = enc_r(3, 2, 5, 6'b101010);
        img[9]  = sw(0, 5, 100);
        img[10] = addi(0, 6, -1);
        img[11] = enc_r(6, 3, 5, 6'b101010);
        img[12] = sw(0, 5, 100);
        img[13] = enc_r(2, 3, 5, 6'b100000);
        img[14] = sw(0, 5, 100);
        img[15] = enc_r(2, 3, 5, 6'b111111);
        img[16] = sw(0, 5, 100);
        img[17] = addi(0, 0, 55);
        img[18] = sw(0, 0, 100);
        img[19] = enc_j(19);
        do_reset("p2");
        run(90);
        chk("p2_nwr", 32'(wr_adr_q.size()), 32'd8);
        chk("p2_sub", wr_d(0), 32'd2);
        chk("p2_and", wr_d(1), 32'd5);
        chk("p2_or", wr_d(2), 32'd7);
        chk("p2_slt_pos", wr_d(3), 32'd1);
        chk("p2_slt_neg", wr_d(4), 32'd1);
        chk("p2_add", wr_d(5), 32'd12);
        chk("p2_bad_funct", wr_d(6), 32'd0);
        chk("p2_reg0", wr_d(7), 32'd0);
        chk("p2_adr", wr_a(3), 32'd100);

        // Program 3: lw/sw round trip through memory.
        clear_img();
        img[0]  = lw(0, 2, 200);
        img[1]  = sw(0, 2, 64);
        img[2]  = lw(0, 6, 64);
        img[3]  = sw(0, 6, 68);
        img[4]  = enc_j(4);
        img[50] = 32'h12345678;
        do_reset("p3");
        run(26);
        chk("p3_nwr", 32'(wr_adr_q.size()), 32'd2);
        chk("p3_sw1_adr", wr_a(0), 32'd64);
        chk("p3_sw1_data", wr_d(0), 32'h12345678);
        chk("p3_sw1_cycle", wr_c(0), 32'd9);
        chk("p3_sw2_adr", wr_a(1), 32'd68);
        chk("p3_sw2_data", wr_d(1), 32'h12345678);
        chk("p3_sw2_cycle", wr_c(1), 32'd18);

        // Program 4: taken beq, untaken beq, jump.
        clear_img();
        img[0]  = addi(0, 2, 1);
        img[1]  = beq(0, 0, 1);
        img[2]  = sw(0, 2, 100);
        img[3]  = sw(0, 2, 104);
        img[4]  = beq(2, 0, 1);
        img[5]  = sw(0, 2, 108);
        img[6]  = enc_j(10);
        img[7]  = sw(0, 2, 116);
        img[8]  = sw(0, 2, 116);
        img[9]  = sw(0, 2, 116);
        img[10] = sw(0, 2, 112);
        img[11] = enc_j(11);
        do_reset("p4");
        run(40);
        chk("p4_nwr", 32'(wr_adr_q.size()), 32'd3);
        chk("p4_taken_adr", wr_a(0), 32'd104);
        chk("p4_taken_cycle", wr_c(0), 32'd11);
        chk("p4_fall_adr", wr_a(1), 32'd108);
        chk("p4_fall_cycle", wr_c(1), 32'd18);
        chk("p4_jump_fetch", adr_at[22], 32'd40);
        chk("p4_jump_adr", wr_a(2), 32'd112);
        chk("p4_jump_data", wr_d(2), 32'd1);

        // Program 5: reset asserted during MEMWR aborts the store.
        clear_img();
        img[0] = addi(0, 2, 9);
        img[1] = sw(0, 2, 100);
        img[2] = enc_j(2);
        do_reset("p5");
        repeat (7) @(posedge clk);
        #1;
        chk("p5_in_memwr", {31'b0, memwrite}, 32'd1);
        chk("p5_memwr_adr", adr, 32'd100);
        chk("p5_nwr_before", 32'(wr_adr_q.size()), 32'd0);
        reset = 1'b0;
        #1;
        chk("p5_memwrite_masked", {31'b0, memwrite}, 32'd0);
        @(posedge clk);
        #1;
        chk("p5_mem_untouched", mem[25], 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("p5_refetch_adr", adr, 32'd0);
        chk("p5_refetch_memread", {31'b0, memread}, 32'd1);
        run(10);
        chk("p5_rerun_store", mem[25], 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
